hier_snap_serializer: RTL and testbench

//   Downstream consumer of the generated top/mid/bot instance hierarchy.
//   On a snapshot request, captures one register value per generated bot lane

---
 rtl/hier_snap_serializer.sv | 108 ++++++++++
 tb/tb_hier_snap_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hier_snap_serializer.sv
// hier_snap_serializer
// Captures one value per bot lane into shadow storage when a snapshot is
// requested, then streams the frozen lanes out one beat at a time over a
// valid/ready interface. Requests that arrive while a stream is in flight
// are counted in a saturating drop counter instead of being captured.

module hier_snap_serializer #(
   parameter int NUM_LANES = 3,
   parameter int LANE_W    = 8,
   parameter int IDX_W     = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_LANES*LANE_W-1:0] i_lane_data,
   input  logic                        i_snap_req,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [LANE_W-1:0]           o_out_data,
   output logic [IDX_W-1:0]            o_out_idx,
   output logic                        o_out_last,
   output logic                        o_busy,
   output logic [7:0]                  o_drop_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } StateT;

   StateT                        r_state;
   StateT                        w_nextState;
   logic [NUM_LANES*LANE_W-1:0]  r_shadow;
   logic [IDX_W-1:0]             r_idx;
   logic [7:0]                   r_dropCnt;
   logic                         w_accept;
   logic                         w_lastBeat;

   // A beat is consumed only while streaming and the consumer is ready;
   // the last beat is the one carrying the highest lane index.
   assign w_accept   = (r_state == SEND) && i_out_ready;
   assign w_lastBeat = (r_idx == IDX_W'(NUM_LANES - 1));

   // State register; reset abandons any partial stream immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: start streaming on a request, return to idle once the
   // last beat has been accepted.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (i_snap_req) begin
               w_nextState = SEND;
            end
         end
         SEND: begin
            if (w_accept && w_lastBeat) begin
               w_nextState = IDLE;
            end
         end
      endcase
   end

   // Shadow capture and beat index. The shadow is written only from IDLE,
   // so it stays frozen for the whole stream regardless of lane activity.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow <= '0;
         r_idx    <= '0;
      end else if (r_state == IDLE) begin
         if (i_snap_req) begin
            r_shadow <= i_lane_data;
            r_idx    <= '0;
         end
      end else if (w_accept) begin
         if (w_lastBeat) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   // Requests seen while streaming (including on the final handshake) are
   // ignored for capture and counted, saturating at 255.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dropCnt <= '0;
      end else if (i_snap_req && (r_state == SEND) && (r_dropCnt != 8'hFF)) begin
         r_dropCnt <= r_dropCnt + 8'd1;
      end
   end

   // Data is a mux over the frozen shadow, so it holds while a beat stalls.
   assign o_out_valid = (r_state == SEND);
   assign o_busy      = (r_state == SEND);
   assign o_out_data  = r_shadow[int'(r_idx) * LANE_W +: LANE_W];
   assign o_out_idx   = r_idx;
   assign o_out_last  = (r_state == SEND) && w_lastBeat;
   assign o_drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_hier_snap_serializer.sv
// tb_hier_snap_serializer
// Drives the three-lane serializer through directed and random sequences
// while a queue-based model predicts each beat, and exercises a one-lane
// instance separately.

module tb_hier_snap_serializer;

   localparam int N  = 3;
   localparam int LW = 8;

   logic          clk;
   logic          rst_n;
   logic [N*LW-1:0] laneData;
   logic          snapReq;
   logic          outReady;
   logic          outValid;
   logic [LW-1:0] outData;
   logic [1:0]    outIdx;
   logic          outLast;
   logic          busy;
   logic [7:0]    dropCnt;

   logic          s1Snap;
   logic [3:0]    s1Lane;
   logic          s1Valid;
   logic [3:0]    s1Data;
   logic [0:0]    s1Idx;
   logic          s1Last;
   logic          s1Busy;
   logic [7:0]    s1Drop;

   int total;
   int bad;

   logic [7:0] mQ[$];
   int         mDrop;

   hier_snap_serializer #(.NUM_LANES(N), .LANE_W(LW), .IDX_W(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_lane_data (laneData),
      .i_snap_req  (snapReq),
      .o_out_valid (outValid),
      .i_out_ready (outReady),
      .o_out_data  (outData),
      .o_out_idx   (outIdx),
      .o_out_last  (outLast),
      .o_busy      (busy),
      .o_drop_cnt  (dropCnt)
   );

   hier_snap_serializer #(.NUM_LANES(1), .LANE_W(4), .IDX_W(1)) dutOne (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_lane_data (s1Lane),
      .i_snap_req  (s1Snap),
      .o_out_valid (s1Valid),
      .i_out_ready (1'b1),
      .o_out_data  (s1Data),
      .o_out_idx   (s1Idx),
      .o_out_last  (s1Last),
      .o_busy      (s1Busy),
      .o_drop_cnt  (s1Drop)
   );

   // Free-running clock shared by both instances.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model view: a stream is pending while beats remain in the queue; the
   // beat index is how many beats of this stream are already gone.
   task automatic checkOutput();
      int remaining;
      remaining = mQ.size();
      check("valid", 32'(outValid), 32'(remaining != 0));
      check("busy",  32'(busy),     32'(remaining != 0));
      check("idx",   32'(outIdx),   (remaining != 0) ? 32'(N - remaining) : 32'd0);
      check("last",  32'(outLast),  32'(remaining == 1));
      check("drop",  32'(dropCnt),  32'(mDrop));
      if (remaining != 0) begin
         check("data", 32'(outData), 32'(mQ[0]));
      end
   endtask

   // One clock cycle: check the current outputs, apply inputs, advance the
   // model by the rules of the interface, then return at the falling edge.
   task automatic applyStimulus(input logic snap, input logic ready, input logic [N*LW-1:0] lanes);
      logic busyBefore;
      checkOutput();
      snapReq  = snap;
      outReady = ready;
      laneData = lanes;
      @(posedge clk);
      busyBefore = (mQ.size() != 0);
      if (snap && busyBefore && mDrop < 255) mDrop++;
      if (busyBefore && ready) void'(mQ.pop_front());
      if (snap && !busyBefore) begin
         for (int i = 0; i < N; i++) mQ.push_back(lanes[i*LW +: LW]);
      end
      @(negedge clk);
   endtask

   localparam logic [N*LW-1:0] LANES_A = {8'h33, 8'h22, 8'h11};
   localparam logic [N*LW-1:0] LANES_F = {8'hFF, 8'hFF, 8'hFF};

   initial begin
      total    = 0;
      bad      = 0;
      mDrop    = 0;
      rst_n    = 1'b0;
      snapReq  = 1'b0;
      outReady = 1'b1;
      laneData = '0;
      s1Snap   = 1'b0;
      s1Lane   = 4'hA;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_data", 32'(outData), 32'd0);
      checkOutput();
      rst_n = 1'b1;
      @(negedge clk);

      // Plain stream with ready high
      applyStimulus(1'b1, 1'b1, LANES_A);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, LANES_A);

      // Stall on beat 1 while lanes change to FF behind the frozen shadow
      applyStimulus(1'b1, 1'b1, LANES_A);
      applyStimulus(1'b0, 1'b1, LANES_F);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, LANES_F);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, LANES_F);

      // Requests while busy, including on the last-beat handshake
      applyStimulus(1'b1, 1'b1, LANES_A);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, LANES_F);
      applyStimulus(1'b0, 1'b1, LANES_F);
      applyStimulus(1'b0, 1'b1, LANES_F);
      check("drop3", 32'(dropCnt), 32'd3);

      // Saturation of the drop counter
      applyStimulus(1'b1, 1'b1, LANES_A);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, LANES_A);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, LANES_A);
      check("drop_sat", 32'(dropCnt), 32'd255);

      // Reset in the middle of a stream, on beat 1
      applyStimulus(1'b1, 1'b1, LANES_A);
      applyStimulus(1'b0, 1'b1, LANES_A);
      checkOutput();
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(outValid), 32'd0);
      check("rst_mid_busy",  32'(busy),     32'd0);
      check("rst_mid_idx",   32'(outIdx),   32'd0);
      check("rst_mid_data",  32'(outData),  32'd0);
      check("rst_mid_drop",  32'(dropCnt),  32'd0);
      mQ.delete();
      mDrop = 0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, LANES_A);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, LANES_A);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
                       (N*LW)'($urandom));
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, LANES_A);
      checkOutput();

      // Single-lane instance: one beat, busy for exactly one cycle
      check("one_idle_valid", 32'(s1Valid), 32'd0);
      s1Snap = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s1Snap = 1'b0;
      check("one_valid", 32'(s1Valid), 32'd1);
      check("one_data",  32'(s1Data),  32'hA);
      check("one_idx",   32'(s1Idx),   32'd0);
      check("one_last",  32'(s1Last),  32'd1);
      check("one_busy",  32'(s1Busy),  32'd1);
      @(posedge clk);
      @(negedge clk);
      check("one_done_busy",  32'(s1Busy),  32'd0);
      check("one_done_valid", 32'(s1Valid), 32'd0);
      check("one_drop",       32'(s1Drop),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
